// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: fixed-period servo PWM generator.
// Duty requests arrive over valid/ready into a shadow (target) register and are applied only
// at frame boundaries, so the pulse is never glitched mid-frame.
// Optional feature macro: SERVO_SLEW_LIMIT_EN -- limits the duty change per frame to MAX_STEP.
module servo_pwm_gen #(
    parameter int unsigned PERIOD_CYCLES = 1000000,
    parameter int unsigned MIN_DUTY      = 50000,
    parameter int unsigned MAX_DUTY      = 100000,
    parameter int unsigned CENTER_DUTY   = 75000,
    parameter int unsigned MAX_STEP      = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [17:0] duty_in,
    input  logic        duty_valid,
    output logic        duty_ready,
    output logic        pwm_out,
    output logic        period_start,
    output logic [17:0] duty_applied,
    output logic        clamp_flag
);

    localparam int unsigned     CntW       = $clog2(PERIOD_CYCLES);
    localparam logic [CntW-1:0] LastCnt    = CntW'(PERIOD_CYCLES - 1);
    localparam logic [17:0]     MinDuty    = 18'(MIN_DUTY);
    localparam logic [17:0]     MaxDuty    = 18'(MAX_DUTY);
    localparam logic [17:0]     CenterDuty = 18'(CENTER_DUTY);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pwm_q, pwm_d;
    logic            ps_q, ps_d;
    logic [17:0]     duty_q, duty_d;
    logic [17:0]     target_q, target_d;
    logic            pending_q, pending_d;
    logic            clamp_q, clamp_d;

    logic [17:0]     duty_next;
    logic [17:0]     duty_clamped;
    logic            out_of_range;
    logic            high_done;
    logic            accept;

    // Request clamping and pulse-end detection.
    always_comb begin
        out_of_range = (duty_in < MinDuty) || (duty_in > MaxDuty);
        if (duty_in < MinDuty) begin
            duty_clamped = MinDuty;
        end else if (duty_in > MaxDuty) begin
            duty_clamped = MaxDuty;
        end else begin
            duty_clamped = duty_in;
        end
        high_done = (32'(cnt_q) == (32'(duty_q) - 32'd1));
        accept    = duty_valid && !pending_q;
    end

`ifdef SERVO_SLEW_LIMIT_EN
    localparam logic [17:0] StepDuty = 18'(MAX_STEP);

    // Duty for the next frame: step toward target by at most StepDuty.
    always_comb begin
        duty_next = target_q;
        if (target_q > duty_q) begin
            if ((target_q - duty_q) > StepDuty) begin
                duty_next = duty_q + StepDuty;
            end
        end else if ((duty_q - target_q) > StepDuty) begin
            duty_next = duty_q - StepDuty;
        end
    end
`else
    logic unused_max_step;
    assign unused_max_step = ^MAX_STEP;

    // Duty for the next frame: jump straight to target.
    always_comb begin
        duty_next = target_q;
    end
`endif

    // Next-state logic for the frame FSM, counter and duty handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pwm_d     = pwm_q;
        ps_d      = 1'b0;
        duty_d    = duty_q;
        target_d  = target_q;
        pending_d = pending_q;
        clamp_d   = clamp_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                pwm_d = 1'b0;
                if (en) begin
                    state_d   = StHigh;
                    ps_d      = 1'b1;
                    pwm_d     = 1'b1;
                    duty_d    = duty_next;
                    pending_d = 1'b0;
                end
            end
            StHigh: begin
                pwm_d = 1'b1;
                cnt_d = cnt_q + CntW'(1);
                if (high_done) begin
                    state_d = StLow;
                    pwm_d   = 1'b0;
                end
            end
            StLow: begin
                pwm_d = 1'b0;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    cnt_d = '0;
                    if (en) begin
                        state_d   = StHigh;
                        ps_d      = 1'b1;
                        pwm_d     = 1'b1;
                        duty_d    = duty_next;
                        pending_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                pwm_d   = 1'b0;
            end
        endcase

        // Accept wins over the boundary clear so a request is never lost; it was not
        // folded into duty_next, so it applies at the following boundary.
        if (accept) begin
            target_d  = duty_clamped;
            pending_d = 1'b1;
            clamp_d   = out_of_range;
        end
    end

    // State registers; async reset forces the pulse low immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pwm_q     <= 1'b0;
            ps_q      <= 1'b0;
            duty_q    <= CenterDuty;
            target_q  <= CenterDuty;
            pending_q <= 1'b0;
            clamp_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pwm_q     <= pwm_d;
            ps_q      <= ps_d;
            duty_q    <= duty_d;
            target_q  <= target_d;
            pending_q <= pending_d;
            clamp_q   <= clamp_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign duty_applied = duty_q;
    assign clamp_flag   = clamp_q;
    assign duty_ready   = ~pending_q;

endmodule
